int_pending_register: RTL and testbench

INT_PENDING_REGISTER -- requirements
Module: int_pending_register

---
 rtl/int_pending_register.sv | 99 +++++++++
 tb/tb_int_pending_register.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_pending_register.sv
// Interrupt pending register: synchronises five raw device lines and latches them
// as level- or edge-sensitive pending bits with write-1-to-clear and status readback.
module int_pending_register #(
    parameter int unsigned PS2_INT_POS   = 0,
    parameter int unsigned ETH_INT_POS   = 1,
    parameter int unsigned IDE_INT_POS   = 2,
    parameter int unsigned QUART_INT_POS = 3,
    parameter int unsigned TIMER_INT_POS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_raw,
    input  logic        eth_raw,
    input  logic        ide_raw,
    input  logic        quart_raw,
    input  logic        timer_raw,
    input  logic        write,
    input  logic        mode_cs,
    input  logic        clear_cs,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ps2_irq,
    output logic        eth_irq,
    output logic        ide_irq,
    output logic        quart_irq,
    output logic        timer_irq
);

    localparam logic [2:0] P_PS2   = 3'(PS2_INT_POS);
    localparam logic [2:0] P_ETH   = 3'(ETH_INT_POS);
    localparam logic [2:0] P_IDE   = 3'(IDE_INT_POS);
    localparam logic [2:0] P_QUART = 3'(QUART_INT_POS);
    localparam logic [2:0] P_TIMER = 3'(TIMER_INT_POS);

    localparam logic [7:0] IMPL_MASK = (8'h01 << P_PS2)   | (8'h01 << P_ETH) |
                                       (8'h01 << P_IDE)   | (8'h01 << P_QUART) |
                                       (8'h01 << P_TIMER);

    logic [7:0] r_s1;
    logic [7:0] r_s2;
    logic [7:0] r_s3;
    logic [7:0] r_mode;
    logic [7:0] r_pending;

    logic [7:0] w_raw;
    logic [7:0] w_wdata;
    logic       w_wr_mode;
    logic       w_wr_clear;
    logic [7:0] w_set;
    logic [7:0] w_clr;
    logic [7:0] w_edge_next;
    logic [7:0] w_pending_next;

    always_comb begin
        w_raw          = '0;
        w_raw[P_PS2]   = ps2_raw;
        w_raw[P_ETH]   = eth_raw;
        w_raw[P_IDE]   = ide_raw;
        w_raw[P_QUART] = quart_raw;
        w_raw[P_TIMER] = timer_raw;
    end

    assign w_wdata    = data_in[31:24] & IMPL_MASK;
    assign w_wr_mode  = write & mode_cs;
    assign w_wr_clear = write & clear_cs;

    // Set term is OR'd after the clear mask so a coincident set beats the clear.
    // r_mode is the pre-write value, so a same-cycle mode write never affects the clear.
    assign w_set          = r_s2 & ~r_s3;
    assign w_clr          = w_wr_clear ? w_wdata : '0;
    assign w_edge_next    = w_set | (r_pending & ~w_clr);
    assign w_pending_next = ((r_mode & w_edge_next) | (~r_mode & r_s2)) & IMPL_MASK;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_s3      <= '0;
            r_mode    <= '0;
            r_pending <= '0;
        end else begin
            r_s1      <= w_raw;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_pending <= w_pending_next;
            if (w_wr_mode)
                r_mode <= w_wdata;
        end
    end

    assign data_out  = {r_pending, r_mode, r_s2, 8'h00};

    assign ps2_irq   = r_pending[P_PS2];
    assign eth_irq   = r_pending[P_ETH];
    assign ide_irq   = r_pending[P_IDE];
    assign quart_irq = r_pending[P_QUART];
    assign timer_irq = r_pending[P_TIMER];

endmodule

// File: tb/tb_int_pending_register.sv
// Self-checking bench for int_pending_register: directed scenarios plus random
// traffic compared against a sample-history reference model.
module tb_int_pending_register;

    localparam logic [7:0] MASK = 8'h1F;

    logic        clock;
    logic        reset;
    logic [4:0]  raw;
    logic        write;
    logic        mode_cs;
    logic        clear_cs;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ps2_irq, eth_irq, ide_irq, quart_irq, timer_irq;
    logic [4:0]  irq_obs;

    int tests;
    int fails;

    // Reference model: history of raw samples (index 0 = newest edge), mode and pending.
    logic [7:0] hist[$];
    logic [7:0] mode_m;
    logic [7:0] pend_m;

    int_pending_register #(
        .PS2_INT_POS  (0),
        .ETH_INT_POS  (1),
        .IDE_INT_POS  (2),
        .QUART_INT_POS(3),
        .TIMER_INT_POS(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ps2_raw  (raw[0]),
        .eth_raw  (raw[1]),
        .ide_raw  (raw[2]),
        .quart_raw(raw[3]),
        .timer_raw(raw[4]),
        .write    (write),
        .mode_cs  (mode_cs),
        .clear_cs (clear_cs),
        .data_in  (data_in),
        .data_out (data_out),
        .ps2_irq  (ps2_irq),
        .eth_irq  (eth_irq),
        .ide_irq  (ide_irq),
        .quart_irq(quart_irq),
        .timer_irq(timer_irq)
    );

    assign irq_obs = {timer_irq, quart_irq, ide_irq, eth_irq, ps2_irq};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [7:0] sample_age(input int unsigned age);
        if (age < hist.size())
            return hist[age];
        return 8'h00;
    endfunction

    // Before this edge's sample is recorded, age 1 is the raw value two edges back
    // (what reaches s2) and age 2 is the one three edges back.
    task automatic model_edge();
        logic [7:0] older;
        logic [7:0] oldest;
        logic [7:0] clr;
        older  = sample_age(1);
        oldest = sample_age(2);
        clr    = (write && clear_cs) ? data_in[31:24] : 8'h00;
        for (int b = 0; b < 8; b++) begin
            if (mode_m[b])
                pend_m[b] = (older[b] && !oldest[b]) || (pend_m[b] && !clr[b]);
            else
                pend_m[b] = older[b];
        end
        pend_m = pend_m & MASK;
        if (write && mode_cs)
            mode_m = data_in[31:24] & MASK;
        hist.push_front({3'b000, raw});
        if (hist.size() > 4)
            void'(hist.pop_back());
    endtask

    task automatic model_reset();
        hist.delete();
        mode_m = 8'h00;
        pend_m = 8'h00;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_irq"},  {27'd0, irq_obs}, {27'd0, pend_m[4:0]});
        chk({tag, "_dout"}, data_out, {pend_m, mode_m, sample_age(1), 8'h00});
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset)
            model_edge();
        #1;
        check_model("model");
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    task automatic cpu_write(input logic m, input logic c, input logic [7:0] d);
        write    = 1'b1;
        mode_cs  = m;
        clear_cs = c;
        data_in  = {d, 24'h00_0000};
        tick();
        write    = 1'b0;
        mode_cs  = 1'b0;
        clear_cs = 1'b0;
        data_in  = '0;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        reset    = 1'b1;
        raw      = '0;
        write    = 1'b0;
        mode_cs  = 1'b0;
        clear_cs = 1'b0;
        data_in  = '0;
        model_reset();

        // Reset state; writes and raw lines ignored while reset is high.
        #2;
        raw = 5'h1F;
        write = 1'b1; mode_cs = 1'b1; data_in = 32'hFF00_0000;
        #20;
        chk("rst_dout", data_out, 32'h0);
        chk("rst_irq", {27'd0, irq_obs}, 32'h0);
        raw = '0; write = 1'b0; mode_cs = 1'b0; data_in = '0;
        #1 reset = 1'b0;
        ticks(3);

        // Level timer: three edges of latency on rise and fall.
        raw[4] = 1'b1;
        ticks(2);
        chk("lvl_timer_rise_early", {31'd0, timer_irq}, 32'd0);
        tick();
        chk("lvl_timer_rise", {31'd0, timer_irq}, 32'd1);
        raw[4] = 1'b0;
        ticks(2);
        chk("lvl_timer_fall_early", {31'd0, timer_irq}, 32'd1);
        tick();
        chk("lvl_timer_fall", {31'd0, timer_irq}, 32'd0);

        // Readback of mode write 8'hA5: only implemented bits appear.
        cpu_write(1'b1, 1'b0, 8'hA5);
        chk("rb_mode", {24'd0, data_out[23:16]}, 32'h05);
        chk("rb_low", {24'd0, data_out[7:0]}, 32'h00);

        // Edge eth: pulse captured once, cleared by W1C.
        cpu_write(1'b1, 1'b0, 8'h02);
        raw[1] = 1'b1;
        ticks(4);
        raw[1] = 1'b0;
        ticks(4);
        chk("edge_eth_hold", {31'd0, eth_irq}, 32'd1);
        cpu_write(1'b0, 1'b1, 8'h02);
        chk("edge_eth_clr", {31'd0, eth_irq}, 32'd0);

        // Edge ide held high: no re-set until a fresh rising edge.
        cpu_write(1'b1, 1'b0, 8'h04);
        raw[2] = 1'b1;
        ticks(4);
        chk("edge_ide_set", {31'd0, ide_irq}, 32'd1);
        cpu_write(1'b0, 1'b1, 8'h04);
        chk("edge_ide_clr", {31'd0, ide_irq}, 32'd0);
        ticks(5);
        chk("edge_ide_held", {31'd0, ide_irq}, 32'd0);
        raw[2] = 1'b0;
        ticks(3);
        raw[2] = 1'b1;
        ticks(3);
        chk("edge_ide_reset", {31'd0, ide_irq}, 32'd1);
        raw[2] = 1'b0;

        // Edge quart: set and clear on the same edge, set wins.
        cpu_write(1'b1, 1'b0, 8'h08);
        raw[3] = 1'b1;
        ticks(2);
        raw[3] = 1'b0;
        ticks(4);
        chk("edge_quart_first", {31'd0, quart_irq}, 32'd1);
        raw[3] = 1'b1;
        ticks(2);
        cpu_write(1'b0, 1'b1, 8'h08);
        chk("edge_quart_collide", {31'd0, quart_irq}, 32'd1);
        cpu_write(1'b0, 1'b1, 8'h08);
        chk("edge_quart_clr", {31'd0, quart_irq}, 32'd0);

        // Mode write plus clear in one cycle: clear judged under the old (edge) mode.
        raw[3] = 1'b0;
        ticks(3);
        raw[3] = 1'b1;
        ticks(4);
        write = 1'b1; mode_cs = 1'b1; clear_cs = 1'b1; data_in = 32'h0000_0000;
        tick();
        write = 1'b0; mode_cs = 1'b0; clear_cs = 1'b0;
        ticks(2);
        raw[3] = 1'b0;

        // Async reset with all lines high in level mode.
        cpu_write(1'b1, 1'b0, 8'h00);
        raw = 5'h1F;
        ticks(4);
        chk("async_pre", {27'd0, irq_obs}, 32'h1F);
        #3 reset = 1'b1;
        model_reset();
        #1;
        chk("async_irq", {27'd0, irq_obs}, 32'h0);
        chk("async_dout", data_out, 32'h0);
        ticks(2);
        #3 reset = 1'b0;
        ticks(2);
        chk("async_rel_early", {27'd0, irq_obs}, 32'h0);
        tick();
        chk("async_rel", {27'd0, irq_obs}, 32'h1F);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                raw = 5'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                write    = 1'b1;
                mode_cs  = ($urandom_range(0, 2) == 0);
                clear_cs = ($urandom_range(0, 1) == 0);
                data_in  = $urandom;
            end
            tick();
            write    = 1'b0;
            mode_cs  = 1'b0;
            clear_cs = 1'b0;
            data_in  = '0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
